// File: rtl/flt_pds2_result_buffer.sv
`timescale 1ns/1ps
// Credit-gated first-word-fall-through result buffer for the fixed-latency flt_pds2 core.
// Upstream is throttled so every operand in flight is guaranteed a FIFO slot when its result lands.
module flt_pds2_result_buffer #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                         i_aclk,
    input  logic                         i_areset,
    input  logic [TDATA_WIDTH-1:0]       i_axi4s_a_tdata,
    input  logic                         i_axi4s_a_tvalid,
    output logic                         o_axi4s_a_tready,
    output logic [TDATA_WIDTH-1:0]       o_core_a_tdata,
    output logic                         o_core_a_tvalid,
    input  logic [TDATA_WIDTH-1:0]       i_core_result_tdata,
    input  logic                         i_core_result_tvalid,
    output logic [TDATA_WIDTH-1:0]       o_axi4s_result_tdata,
    output logic                         o_axi4s_result_tvalid,
    input  logic                         i_axi4s_result_tready,
    output logic [$clog2(FIFO_DEPTH):0]  o_level,
    output logic                         o_overflow
);

    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    logic [CNT_WIDTH-1:0]   credit_q, credit_d;
    logic [CNT_WIDTH-1:0]   level_q, level_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
    logic [TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic accept, pop, push, drop, empty, full;

    // Ready depends only on the registered credit count, never on same-cycle inputs.
    assign o_axi4s_a_tready = (credit_q < DEPTH_CNT);
    assign o_core_a_tdata   = i_axi4s_a_tdata;
    assign o_core_a_tvalid  = i_axi4s_a_tvalid & o_axi4s_a_tready;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_CNT);

    assign o_axi4s_result_tvalid = ~empty;
    assign o_axi4s_result_tdata  = empty ? '0 : mem_q[rd_ptr_q];
    assign o_level               = level_q;
    assign o_overflow            = overflow_q;

    assign accept = i_axi4s_a_tvalid & o_axi4s_a_tready;
    assign pop    = o_axi4s_result_tvalid & i_axi4s_result_tready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign push   = i_core_result_tvalid & (~full | pop);
    assign drop   = i_core_result_tvalid & full & ~pop;

    always_comb begin
        credit_d   = credit_q;
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;

        if (accept && !pop && (credit_q < DEPTH_CNT)) begin
            credit_d = credit_q + CNT_WIDTH'(1);
        end else if (!accept && pop && (credit_q != '0)) begin
            credit_d = credit_q - CNT_WIDTH'(1);
        end

        if (push && !pop) begin
            level_d = level_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            level_d = level_q - CNT_WIDTH'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            credit_q   <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the output is masked to zero while empty.
    always_ff @(posedge i_aclk) begin
        if (push && !i_areset) begin
            mem_q[wr_ptr_q] <= i_core_result_tdata;
        end
    end

endmodule

// File: tb/tb_flt_pds2_result_buffer.sv
`timescale 1ns/1ps
// Directed bench for flt_pds2_result_buffer with a 14-cycle core model and a result scoreboard.
module tb_flt_pds2_result_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a_tdata, core_a_tdata, cr_tdata, r_tdata, force_d;
    logic         a_tvalid, a_tready, core_a_tvalid, cr_tvalid, r_tvalid, r_tready, force_v;
    logic [4:0]   level;
    logic         overflow;

    always #5 clk = ~clk;

    flt_pds2_result_buffer #(.TDATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .i_aclk                (clk),
        .i_areset              (rst),
        .i_axi4s_a_tdata       (a_tdata),
        .i_axi4s_a_tvalid      (a_tvalid),
        .o_axi4s_a_tready      (a_tready),
        .o_core_a_tdata        (core_a_tdata),
        .o_core_a_tvalid       (core_a_tvalid),
        .i_core_result_tdata   (cr_tdata),
        .i_core_result_tvalid  (cr_tvalid),
        .o_axi4s_result_tdata  (r_tdata),
        .o_axi4s_result_tvalid (r_tvalid),
        .i_axi4s_result_tready (r_tready),
        .o_level               (level),
        .o_overflow            (overflow)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Fixed-latency core: result presented LAT cycles after the operand edge.
    logic         pipe_v [LAT];
    logic [W-1:0] pipe_d [LAT];
    always @(posedge clk) begin
        pipe_v[0] <= core_a_tvalid;
        pipe_d[0] <= model(core_a_tdata);
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign cr_tvalid = pipe_v[LAT-1] | force_v;
    assign cr_tdata  = force_v ? force_d : pipe_d[LAT-1];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_q [$];
    int           stamp_q [$];
    int           cyc = 0;
    int           acc_cnt = 0;
    int           stall_cnt = 0;
    int           cred_m = 0;
    bit           lat_chk = 0;
    bit           hold_p = 0;
    logic [W-1:0] hold_d;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: looks at the values that the next rising edge will act on.
    always @(negedge clk) begin
        bit acc, pp;
        if (rst) begin
            cred_m = 0;
            hold_p = 0;
        end else begin
            acc = a_tvalid && a_tready;
            pp  = r_tvalid && r_tready;
            check("a_tready_credit", 32'(a_tready), 32'(cred_m < DEPTH));
            check("core_a_tvalid", 32'(core_a_tvalid), 32'(acc));
            check("level_max", 32'(level <= 5'(DEPTH)), 32'd1);
            if (hold_p) begin
                check("hold_valid", 32'(r_tvalid), 32'd1);
                check("hold_data", r_tdata, hold_d);
            end
            if (a_tvalid && !a_tready) stall_cnt++;
            if (acc) begin
                exp_q.push_back(model(a_tdata));
                stamp_q.push_back(cyc);
                acc_cnt++;
            end
            if (pp) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("result_data", r_tdata, exp_q.pop_front());
                    if (lat_chk) check("latency", 32'(cyc - stamp_q[0]), 32'd15);
                    void'(stamp_q.pop_front());
                end
            end
            if (acc && !pp && cred_m < DEPTH) cred_m++;
            else if (pp && !acc && cred_m > 0) cred_m--;
            hold_p = r_tvalid && !r_tready;
            hold_d = r_tdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, stall0;
        bit last_xfer;
        logic [W-1:0] head;
        a_tvalid = 1'b0;
        a_tdata  = '0;
        r_tready = 1'b0;
        force_v  = 1'b0;
        force_d  = '0;
        #2 rst = 1'b1;
        #1;
        a_tvalid = 1'b1;
        #1;
        check("rst_core_tvalid", 32'(core_a_tvalid), 32'd1);
        a_tvalid = 1'b0;
        tick(LAT + 2);
        check("rst_r_tvalid", 32'(r_tvalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_a_tready", 32'(a_tready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_r_tdata", r_tdata, 32'd0);

        // Streaming: continuous operands, downstream always ready
        rst = 1'b0;
        r_tready = 1'b1;
        lat_chk = 1'b1;
        acc0 = acc_cnt;
        stall0 = stall_cnt;
        for (int i = 0; i < 1000; i++) begin
            a_tdata  = $urandom;
            a_tvalid = 1'b1;
            tick(1);
            if (i == 0) check("first_accept", 32'(acc_cnt - acc0), 32'd1);
        end
        a_tvalid = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        lat_chk = 1'b0;
        check("stream_accepts", 32'(acc_cnt - acc0), 32'd1000);
        check("stream_stalls", 32'(stall_cnt - stall0), 32'd0);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Stall: downstream blocked, operands continuous
        r_tready = 1'b0;
        acc0 = acc_cnt;
        a_tvalid = 1'b1;
        a_tdata = $urandom;
        for (int i = 1; i <= 32; i++) begin
            tick(1);
            if (a_tready) a_tdata = $urandom;
            if (i == 15) check("stall_ready_15", 32'(a_tready), 32'd1);
            if (i == 16) check("stall_ready_16", 32'(a_tready), 32'd0);
            if (i == 29) check("stall_level_29", 32'(level), 32'd15);
            if (i == 30) check("stall_level_30", 32'(level), 32'd16);
        end
        check("stall_accepts", 32'(acc_cnt - acc0), 32'd16);
        check("stall_overflow", 32'(overflow), 32'd0);

        // Release: drain 16 results with no gaps
        a_tvalid = 1'b0;
        r_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 32'(r_tvalid), 32'd1);
            tick(1);
            if (i == 0) check("release_ready", 32'(a_tready), 32'd1);
        end
        check("drain_level", 32'(level), 32'd0);
        check("drain_empty", 32'(r_tvalid), 32'd0);
        check("drain_sb", 32'(exp_q.size()), 32'd0);

        // Full boundary: refill to 16, then forced pushes
        r_tready = 1'b0;
        a_tvalid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_tdata = $urandom;
            tick(1);
        end
        a_tvalid = 1'b0;
        check("full_level", 32'(level), 32'd16);
        force_d = 32'hDEAD_BEEF;
        force_v = 1'b1;
        r_tready = 1'b1;
        exp_q.push_back(force_d);
        stamp_q.push_back(cyc);
        tick(1);
        check("full_pushpop_level", 32'(level), 32'd16);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        force_d = 32'hBAD0_0BAD;
        r_tready = 1'b0;
        head = exp_q[0];
        check("full_head_before", r_tdata, head);
        tick(1);
        force_v = 1'b0;
        check("full_drop_ovf", 32'(overflow), 32'd1);
        check("full_drop_level", 32'(level), 32'd16);
        check("full_drop_head", r_tdata, head);
        r_tready = 1'b1;
        tick(16);
        check("full_drain_level", 32'(level), 32'd0);
        check("full_drain_sb", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-stream: 9 stored, 5 in flight
        r_tready = 1'b0;
        a_tvalid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            a_tdata = $urandom;
            tick(1);
        end
        a_tvalid = 1'b0;
        tick(9);
        check("mid_level_9", 32'(level), 32'd9);
        rst = 1'b1;
        a_tvalid = 1'b1;
        #1;
        check("mid_rst_core_tvalid", 32'(core_a_tvalid), 32'd1);
        check("mid_rst_level_now", 32'(level), 32'd0);
        a_tvalid = 1'b0;
        exp_q.delete();
        stamp_q.delete();
        tick(1);
        check("mid_rst_r_tvalid", 32'(r_tvalid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_a_tready", 32'(a_tready), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_r_tdata", r_tdata, 32'd0);
        tick(LAT + 2);
        rst = 1'b0;

        // Random handshakes on both sides
        acc0 = acc_cnt;
        last_xfer = 1'b0;
        for (int c = 0; c < 20000 && (acc_cnt - acc0) < 2000; c++) begin
            if (!a_tvalid || last_xfer) begin
                a_tvalid = 1'($urandom_range(1, 0));
                a_tdata  = $urandom;
            end
            r_tready = 1'($urandom_range(1, 0));
            last_xfer = a_tvalid && a_tready;
            tick(1);
        end
        a_tvalid = 1'b0;
        r_tready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("rand_accepts", 32'(acc_cnt - acc0), 32'd2000);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_level", 32'(level), 32'd0);
        check("rand_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/flt_pds2_result_buffer.md
FLT_PDS2_RESULT_BUFFER -- requirements
Module: flt_pds2_result_buffer

Parameters
REQ-001 TDATA_WIDTH SHALL default to 32 and set the byte-padded AXI4-Stream data width on every data port.
REQ-002 FIFO_DEPTH SHALL default to 16, be a power of two >= 2, and set result storage and the credit limit.
REQ-003 CNT_WIDTH SHALL equal clog2(FIFO_DEPTH)+1 and be derived internally, not user-set.

Interface
REQ-004 i_aclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_areset  in  1  asynchronous, active-high reset.
REQ-006 i_axi4s_a_tdata  in  TDATA_WIDTH  operand from upstream source.
REQ-007 i_axi4s_a_tvalid  in  1  operand valid.
REQ-008 o_axi4s_a_tready  out  1  upstream may transfer; combinational from registered credit count only.
REQ-009 o_core_a_tdata  out  TDATA_WIDTH  operand to fixed-latency flt_pds2 core (pass-through of i_axi4s_a_tdata).
REQ-010 o_core_a_tvalid  out  1  = i_axi4s_a_tvalid & o_axi4s_a_tready.
REQ-011 i_core_result_tdata  in  TDATA_WIDTH  core result.
REQ-012 i_core_result_tvalid  in  1  core result valid; core has no backpressure.
REQ-013 o_axi4s_result_tdata  out  TDATA_WIDTH  buffered result to downstream.
REQ-014 o_axi4s_result_tvalid  out  1  FIFO non-empty.
REQ-015 i_axi4s_result_tready  in  1  downstream accept.
REQ-016 o_level  out  CNT_WIDTH  current FIFO occupancy.
REQ-017 o_overflow  out  1  sticky: core result arrived with FIFO full and no pop.

Function
REQ-018 Accept event SHALL be i_axi4s_a_tvalid & o_axi4s_a_tready; pop event SHALL be o_axi4s_result_tvalid & i_axi4s_result_tready; push event SHALL be i_core_result_tvalid.
REQ-019 Credit counter SHALL track operands in flight plus FIFO entries: +1 on accept, -1 on pop, unchanged on accept & pop same cycle.
REQ-020 o_axi4s_a_tready SHALL be 1 iff credit count < FIFO_DEPTH, guaranteeing the FIFO never overflows regardless of core latency.
REQ-021 FIFO SHALL be first-word fall-through: entry written on cycle N visible on o_axi4s_result_tdata with tvalid=1 at cycle N+1.
REQ-022 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; full/empty derived from o_level.
REQ-023 Push and pop in the same cycle SHALL both occur and leave o_level unchanged, including when full or when level=1.
REQ-024 Push with FIFO full and no pop SHALL drop the result, leave FIFO contents and pointers unchanged, and set o_overflow=1 until reset.
REQ-025 Pop with FIFO empty SHALL be impossible (tvalid=0); pointers unchanged.
REQ-026 Output data and tvalid SHALL be stable while tvalid=1 and tready=0 (AXI4-Stream rule).
REQ-027 Results SHALL leave in the order the core produced them; no reordering, duplication or loss while o_overflow=0.
REQ-028 Credit count SHALL saturate at 0 and FIFO_DEPTH; decrement below 0 or increment above FIFO_DEPTH SHALL not occur.

Reset
REQ-029 While i_areset=1: credit=0, pointers=0, o_level=0, o_axi4s_result_tvalid=0, o_overflow=0, o_axi4s_a_tready=1, o_core_a_tvalid=i_axi4s_a_tvalid.
REQ-030 Reset asserted mid-operation SHALL discard all stored and in-flight accounting immediately; results arriving after release without matching credit are pushed normally if space exists.
REQ-031 First accept SHALL be possible on the first rising edge after i_areset deasserts.
REQ-032 o_axi4s_result_tdata reset value SHALL be 0.

Verification (FIFO_DEPTH=16, core model latency 14)
REQ-033 Streaming: 1000 random operands, tvalid=1, result tready=1 -> tready never drops, 1000 results in order, each = model(input), latency 15 cycles input-to-output.
REQ-034 Stall: result tready=0, tvalid=1 continuous -> exactly 16 accepts, a_tready=0 from cycle 16, o_level reaches 16 by cycle 30, o_overflow stays 0.
REQ-035 Release: after REQ-034 set result tready=1 -> 16 results drained in order, a_tready=1 the cycle after first pop, no gaps in output while data remains.
REQ-036 Full-boundary: level=16, simultaneous pop and forced core push -> level stays 16, o_overflow=0; forced push without pop -> o_overflow=1, data unchanged.
REQ-037 Reset mid-stream: assert i_areset with level=9 and 5 in flight -> next cycle tvalid=0, o_level=0, a_tready=1, o_overflow=0.
REQ-038 Random tready (50%) on both sides, 2000 operands -> scoreboard matches all results, o_overflow=0, credit never exceeds 16.
